ins_mem_ctrl: RTL
=================

Name: ins_mem_ctrl

Overview:
- Instruction-memory stage directly upstream of the cpu core.
- Accepts a fetch request (`addr`, `en_ram_in`) from the core and returns the 16-bit instruction on `ins` with a one-cycle `en_ram_out` strobe after a programmable latency.
- Provides a side-band program-load port so the testbench or a boot loader can write the instruction array while the core is held or idle.
- Flags out-of-range fetches.

Parameters:
- ADDR_W, 8, word-address bits implemented; array depth = 2^ADDR_W words of 16 bits.
- LATENCY, 2, cycles from request acceptance to the `en_ram_out` strobe; legal range 1..15.
- NOP_WORD, 16'h0000, instruction returned for out-of-range fetches.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- addr, input, 16, fetch word address from the core's PC.
- en_ram_in, input, 1, fetch request from the core; sampled only in IDLE.
- ins, output, 16, returned instruction; held stable between responses.
- en_ram_out, output, 1, one-cycle strobe meaning `ins` is valid this cycle.
- busy, output, 1, high from request acceptance through the `en_ram_out` cycle.
- addr_err, output, 1, one-cycle pulse coincident with `en_ram_out` when a fetch was out of range.
- ld_en, input, 1, program-load write enable.
- ld_addr, input, ADDR_W, program-load word address.
- ld_data, input, 16, program-load write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - ins=16'h0000, en_ram_out=0, busy=0, addr_err=0.
  - Array contents are not cleared.
- FSM states:
  - IDLE:
    - en_ram_in=1: latch addr into req_addr, load counter with LATENCY-1, set busy=1.
    - Go to RESP if LATENCY=1, else WAIT.
  - WAIT:
    - Decrement counter each cycle.
    - When counter reaches 1, go to RESP.
  - RESP (one cycle):
    - ins <= array[req_addr[ADDR_W-1:0]], or NOP_WORD if req_addr[15:ADDR_W] != 0.
    - en_ram_out=1 and addr_err as defined above.
    - Return to IDLE; busy drops on the following cycle.
- Latency:
  - Request sampled at edge N gives en_ram_out=1 during the cycle after edge N+LATENCY.
  - Example, LATENCY=2: request at edge 0, strobe high after edge 2.
- Back-to-back:
  - No new request is accepted in the RESP cycle.
  - The earliest next acceptance is the first IDLE cycle, so throughput is one fetch per LATENCY+1 cycles.
- en_ram_in while busy is ignored and not queued. The core is required to hold or re-assert it.
- ins and addr_err are registered outputs; en_ram_out is registered (no combinational path from inputs to outputs).
- Program load:
  - ld_en=1 writes ld_data to array[ld_addr] at the edge.
  - Allowed in any state.
  - The read happens at the RESP edge, so a load to req_addr committed on an earlier edge is visible. A load on the same edge as the RESP read returns the old data (read-before-write).
- Reset mid-fetch aborts the fetch: no en_ram_out, state returns to IDLE.

Decomposition:
- Shared package `ins_mem_pkg`:
  - state enum {IDLE, WAIT, RESP}.
  - NOP_WORD default.
  - Width constant INS_W=16.
- Sub-module `ins_ram_array`:
  - Single-port-write / single-port-read synchronous array (ADDR_W, 16).
  - Registered read, read-before-write.
  - Instantiated once; the FSM and counter stay in the top.

Test Plan:
1. Reset then load: with rst=0 then 1, ld array[0..3]=16'h1101,16'h2202,16'h3303,16'h4404 → ins=16'h0000, en_ram_out=0, busy=0 throughout.
2. Single fetch, LATENCY=2: addr=2 with en_ram_in pulsed → en_ram_out high exactly 3 cycles after the request cycle, ins=16'h3303, addr_err=0, busy high for 3 cycles.
3. Ignored request: en_ram_in held high with addr=1 then changed to 3 during WAIT → response ins=16'h2202 (addr=1), the next fetch accepted one cycle after RESP returns 16'h4404; strobes exactly LATENCY+1 cycles apart.
4. Out-of-range fetch: addr=16'h0100 with ADDR_W=8 → ins=NOP_WORD=16'h0000, addr_err=1 for exactly the en_ram_out cycle.
5. Load during WAIT: fetch addr=0, then ld array[0]=16'hABCD one cycle later → returned ins=16'hABCD; the same load issued on the RESP edge instead returns 16'h1101.
6. Reset mid-fetch: rst=0 during WAIT → no en_ram_out, busy=0 immediately; the next fetch after release behaves per test 2. Repeat test 2 with LATENCY=1 → strobe 2 cycles after request.

Source files
------------

// File: rtl/ins_mem_pkg.sv
// Shared types and constants for the instruction-memory stage.
package ins_mem_pkg;

  // Instruction and fetch-address width seen by the core.
  localparam int unsigned INS_W = 16;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  // Instruction returned when a fetch falls outside the implemented array.
  localparam logic [INS_W-1:0] NOP_WORD_DEF = 16'h0000;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when any address bit above the implemented word-address range is set.
  function automatic logic addr_out_of_range(input logic [INS_W-1:0] a,
                                             input int unsigned      aw);
    logic [INS_W-1:0] hi;
    hi = a >> aw;
    return (hi != '0);
  endfunction

endpackage

// File: rtl/ins_ram_array.sv
// Instruction array: one write port for program load, one registered read
// port for fetches. A read and a write to the same word on the same edge
// return the old contents (read-before-write).
module ins_ram_array
  import ins_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = INS_W
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Program-load write port; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ins_mem_ctrl.sv
// Instruction-memory stage between the core's PC and the instruction
// register. A fetch is accepted in IDLE, waits LATENCY-1 cycles, reads the
// array at the RESP edge and strobes en_ram_out for one cycle with the word.
//
// Handshake: en_ram_in is a request level, sampled only while the FSM is in
// IDLE; requests arriving during WAIT or RESP are discarded without any
// back-pressure indication, so the core must hold or re-assert it. en_ram_out
// is a one-cycle valid pulse; ins is held stable until the next pulse. busy
// is high from the cycle after acceptance through the en_ram_out cycle.
module ins_mem_ctrl
  import ins_mem_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 8,
  parameter int unsigned      LATENCY  = 2,
  parameter logic [INS_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INS_W-1:0]  addr,
  input  logic              en_ram_in,
  output logic [INS_W-1:0]  ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic              addr_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INS_W-1:0]  ld_data,
  output state_e            dbg_state_o
);

  // Counter reload value: cycles spent in IDLE->WAIT->RESP before the read.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [INS_W-1:0]  req_addr_q;
  logic              en_ram_out_q;
  logic              busy_q;
  logic              addr_err_q;
  logic              last_oor_q;

  logic              req_oor;
  logic              rd_en;
  logic [INS_W-1:0]  ram_rd_data;

  // Out-of-range decode of the latched fetch address.
  assign req_oor = addr_out_of_range(req_addr_q, ADDR_W);

  // The array is read exactly once per fetch, on the RESP edge.
  assign rd_en = (state_q == RESP);

  ins_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (INS_W)
  ) u_ram (
    .clk       (clk),
    .rst_n_i   (rst),
    .wr_en_i   (ld_en),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (req_addr_q[ADDR_W-1:0]),
    .rd_data_o (ram_rd_data)
  );

  // Fetch FSM: accept in IDLE, count down in WAIT, read and strobe from RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      en_ram_out_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      last_oor_q   <= 1'b0;
    end else begin
      en_ram_out_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_ram_in) begin
            req_addr_q <= addr;
            cnt_q      <= LAT_M1;
            busy_q     <= 1'b1;
            state_q    <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          en_ram_out_q <= 1'b1;
          addr_err_q   <= req_oor;
          last_oor_q   <= req_oor;
          cnt_q        <= '0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Both mux inputs are registers updated on the RESP edge, so ins changes
  // only together with en_ram_out and is held otherwise.
  assign ins         = last_oor_q ? NOP_WORD : ram_rd_data;
  assign en_ram_out  = en_ram_out_q;
  assign busy        = busy_q;
  assign addr_err    = addr_err_q;
  assign dbg_state_o = state_q;

endmodule
